// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Owns the single RAM address/write port and shares it between the CPU
//   data port and the DMA controller. One owner per cycle, decided at each
//   posedge from registered state only, so there is no combinational
//   request-to-grant path.
//
//   Request/grant semantics: a master holds its *_req high for as long as it
//   wants the bus; it owns the bus in any cycle where its *_grant is high and
//   its address/data/we reach the RAM only in those cycles. A request is
//   granted at the earliest in the cycle after it was first sampled high.
//
//   DMA tenure alternates read (phase 0) and write (phase 1) cycles. The bus
//   is only ever handed away from a phase-0 evaluation (DMA dropped its
//   request) or at the end of a write cycle, so a read/write pair is never
//   split.
//
// Ports
//   clk        in   clock, all state on posedge
//   rst        in   asynchronous active-low reset
//   cpu_req    in   CPU wants the bus
//   cpu_addr   in   CPU address
//   cpu_wdata  in   CPU write data
//   cpu_we     in   CPU write enable
//   cpu_grant  out  CPU owns the bus this cycle
//   cpu_stall  out  cpu_req & ~cpu_grant
//   dma_req    in   DMA controller bus request
//   dma_addr   in   DMA address
//   dma_wdata  in   DMA write data
//   dma_we     in   DMA write enable
//   dma_grant  out  DMA owns the bus (DMA controller bus_grant)
//   ram_addr   out  muxed RAM address (0 when idle)
//   ram_wdata  out  muxed RAM write data (0 when idle)
//   ram_we     out  owner's write enable, gated by its grant
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int CPU_QUANTUM = 4,
  parameter int DMA_BURST   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic              cpu_grant,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_we,
  output logic              dma_grant,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we
);

  localparam int CCW = (CPU_QUANTUM > 1) ? $clog2(CPU_QUANTUM) : 1;
  localparam int DCW = (DMA_BURST > 1) ? $clog2(DMA_BURST) : 1;
  localparam logic [CCW-1:0] CPU_LAST = CCW'(CPU_QUANTUM - 1);
  localparam logic [DCW-1:0] DMA_LAST = DCW'(DMA_BURST - 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  owner_e         owner_q;
  logic           phase_q;    // DMA tenure: 0 = read cycle, 1 = write cycle
  logic [CCW-1:0] cpu_cnt_q;  // CPU cycles spent while DMA was waiting
  logic [DCW-1:0] dma_cnt_q;  // completed DMA pairs this tenure

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q   <= OWN_NONE;
      phase_q   <= 1'b0;
      cpu_cnt_q <= '0;
      dma_cnt_q <= '0;
    end else begin
      case (owner_q)
        OWN_NONE: begin
          // CPU wins a tie from idle.
          if (cpu_req) begin
            owner_q   <= OWN_CPU;
            cpu_cnt_q <= '0;
            dma_cnt_q <= '0;
          end else if (dma_req) begin
            owner_q   <= OWN_DMA;
            phase_q   <= 1'b0;
            cpu_cnt_q <= '0;
            dma_cnt_q <= '0;
          end
        end

        OWN_CPU: begin
          if (!cpu_req) begin
            owner_q   <= dma_req ? OWN_DMA : OWN_NONE;
            phase_q   <= 1'b0;
            cpu_cnt_q <= '0;
            dma_cnt_q <= '0;
          end else if (dma_req && (cpu_cnt_q == CPU_LAST)) begin
            // Quantum used up while DMA waited: hand over.
            owner_q   <= OWN_DMA;
            phase_q   <= 1'b0;
            cpu_cnt_q <= '0;
            dma_cnt_q <= '0;
          end else if (dma_req) begin
            // Only time spent with DMA waiting counts against the quantum.
            cpu_cnt_q <= cpu_cnt_q + CCW'(1);
          end
        end

        OWN_DMA: begin
          if (!phase_q) begin
            if (dma_req) begin
              // Read cycle done; the write cycle must keep the bus.
              phase_q <= 1'b1;
            end else begin
              owner_q   <= cpu_req ? OWN_CPU : OWN_NONE;
              cpu_cnt_q <= '0;
              dma_cnt_q <= '0;
            end
          end else begin
            // End of a write cycle: the pair is complete. A dropped dma_req
            // here is ignored and picked up at the next read-cycle check.
            phase_q <= 1'b0;
            if (cpu_req && (dma_cnt_q == DMA_LAST)) begin
              owner_q   <= OWN_CPU;
              cpu_cnt_q <= '0;
              dma_cnt_q <= '0;
            end else if (dma_cnt_q != DMA_LAST) begin
              dma_cnt_q <= dma_cnt_q + DCW'(1);
            end
          end
        end

        default: begin
          owner_q   <= OWN_NONE;
          phase_q   <= 1'b0;
          cpu_cnt_q <= '0;
          dma_cnt_q <= '0;
        end
      endcase
    end
  end

  // Grants and the RAM mux depend on the registered owner only.
  assign cpu_grant = (owner_q == OWN_CPU);
  assign dma_grant = (owner_q == OWN_DMA);
  assign cpu_stall = cpu_req & ~cpu_grant;

  assign ram_addr  = cpu_grant ? cpu_addr  : (dma_grant ? dma_addr  : '0);
  assign ram_wdata = cpu_grant ? cpu_wdata : (dma_grant ? dma_wdata : '0);
  assign ram_we    = (cpu_grant & cpu_we) | (dma_grant & dma_we);

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//   Directed bench for bus_arbiter (default parameters: quantum 4, burst 4).
//   Each vector describes one clock cycle: inputs driven after a negedge,
//   outputs checked 1 ns later, then the posedge closes the cycle.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we, dma_req, dma_we;
  logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic       cpu_grant, cpu_stall, dma_grant, ram_we;
  logic [7:0] ram_addr, ram_wdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       creq;
    logic [7:0] caddr;
    logic [7:0] cwd;
    logic       cwe;
    logic       dreq;
    logic [7:0] daddr;
    logic [7:0] dwd;
    logic       dwe;
    logic       e_cg;
    logic       e_dg;
    logic [7:0] e_addr;
    logic [7:0] e_wd;
    logic       e_we;
  } vec_t;

  vec_t vecs[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  bus_arbiter #(
    .ADDR_W(8), .DATA_W(8), .CPU_QUANTUM(4), .DMA_BURST(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_grant (cpu_grant),
    .cpu_stall (cpu_stall),
    .dma_req   (dma_req),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_we    (dma_we),
    .dma_grant (dma_grant),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we)
  );

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic cr, input logic [7:0] ca,
                       input logic [7:0] cw, input logic ce, input logic dr,
                       input logic [7:0] da, input logic [7:0] dw,
                       input logic de);
    rst = r; cpu_req = cr; cpu_addr = ca; cpu_wdata = cw; cpu_we = ce;
    dma_req = dr; dma_addr = da; dma_wdata = dw; dma_we = de;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic add(input logic r, input logic cr, input logic [7:0] ca,
                     input logic [7:0] cw, input logic ce, input logic dr,
                     input logic [7:0] da, input logic [7:0] dw,
                     input logic de, input logic ecg, input logic edg,
                     input logic [7:0] ea, input logic [7:0] ew,
                     input logic ewe);
    vec_t v;
    v.rst = r; v.creq = cr; v.caddr = ca; v.cwd = cw; v.cwe = ce;
    v.dreq = dr; v.daddr = da; v.dwd = dw; v.dwe = de;
    v.e_cg = ecg; v.e_dg = edg; v.e_addr = ea; v.e_wd = ew; v.e_we = ewe;
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic ecg, input logic edg,
                          input logic estall, input logic [7:0] ea,
                          input logic [7:0] ew, input logic ewe);
    chk({tag, ".cpu_grant"}, {7'd0, cpu_grant}, {7'd0, ecg});
    chk({tag, ".dma_grant"}, {7'd0, dma_grant}, {7'd0, edg});
    chk({tag, ".cpu_stall"}, {7'd0, cpu_stall}, {7'd0, estall});
    chk({tag, ".ram_addr"},  ram_addr,  ea);
    chk({tag, ".ram_wdata"}, ram_wdata, ew);
    chk({tag, ".ram_we"},    {7'd0, ram_we}, {7'd0, ewe});
  endtask

  // ---------------- test ----------------
  initial begin
    logic ecg, edg;
    int   idx;

    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    //   rst creq caddr  cwd  cwe dreq daddr  dwd  dwe | cg dg addr  wd   we
    // Reset and CPU alone
    add(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0);
    add(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0);
    add(1, 1, 8'h42, 8'hA5, 1, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0);
    add(1, 1, 8'h42, 8'hA5, 1, 0, 8'h00, 8'h00, 0,  1, 0, 8'h42, 8'hA5, 1);
    // Non-owner DMA write while CPU owns
    add(1, 1, 8'h43, 8'h11, 0, 1, 8'h10, 8'h77, 1,  1, 0, 8'h43, 8'h11, 0);
    add(1, 1, 8'h44, 8'h22, 1, 1, 8'h10, 8'h77, 1,  1, 0, 8'h44, 8'h22, 1);
    add(1, 0, 8'h44, 8'h22, 0, 1, 8'h10, 8'h77, 1,  1, 0, 8'h44, 8'h22, 0);
    add(1, 0, 8'h44, 8'h22, 0, 1, 8'h20, 8'h00, 0,  0, 1, 8'h20, 8'h00, 0);
    add(1, 0, 8'h44, 8'h22, 0, 1, 8'h20, 8'h5A, 1,  0, 1, 8'h20, 8'h5A, 1);
    add(1, 0, 8'h44, 8'h22, 0, 0, 8'h21, 8'h00, 0,  0, 1, 8'h21, 8'h00, 0);
    add(1, 0, 8'h44, 8'h22, 0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0);
    // DMA alone, 3 pairs: grant for 7 cycles
    add(1, 0, 8'h00, 8'h00, 0, 1, 8'h30, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0);
    add(1, 0, 8'h00, 8'h00, 0, 1, 8'h30, 8'h00, 0,  0, 1, 8'h30, 8'h00, 0);
    add(1, 0, 8'h00, 8'h00, 0, 1, 8'h30, 8'h81, 1,  0, 1, 8'h30, 8'h81, 1);
    add(1, 0, 8'h00, 8'h00, 0, 1, 8'h31, 8'h00, 0,  0, 1, 8'h31, 8'h00, 0);
    add(1, 0, 8'h00, 8'h00, 0, 1, 8'h31, 8'h82, 1,  0, 1, 8'h31, 8'h82, 1);
    add(1, 0, 8'h00, 8'h00, 0, 1, 8'h32, 8'h00, 0,  0, 1, 8'h32, 8'h00, 0);
    add(1, 0, 8'h00, 8'h00, 0, 1, 8'h32, 8'h83, 1,  0, 1, 8'h32, 8'h83, 1);
    add(1, 0, 8'h00, 8'h00, 0, 0, 8'h33, 8'h00, 0,  0, 1, 8'h33, 8'h00, 0);
    add(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0);
    // Pair integrity: CPU asks during 4th read cycle
    add(1, 0, 8'h00, 8'h00, 0, 1, 8'h40, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0);
    add(1, 0, 8'h00, 8'h00, 0, 1, 8'h40, 8'h00, 0,  0, 1, 8'h40, 8'h00, 0);
    add(1, 0, 8'h00, 8'h00, 0, 1, 8'h40, 8'h91, 1,  0, 1, 8'h40, 8'h91, 1);
    add(1, 0, 8'h00, 8'h00, 0, 1, 8'h41, 8'h00, 0,  0, 1, 8'h41, 8'h00, 0);
    add(1, 0, 8'h00, 8'h00, 0, 1, 8'h41, 8'h92, 1,  0, 1, 8'h41, 8'h92, 1);
    add(1, 0, 8'h00, 8'h00, 0, 1, 8'h42, 8'h00, 0,  0, 1, 8'h42, 8'h00, 0);
    add(1, 0, 8'h00, 8'h00, 0, 1, 8'h42, 8'h93, 1,  0, 1, 8'h42, 8'h93, 1);
    add(1, 1, 8'h50, 8'h99, 1, 1, 8'h43, 8'h00, 0,  0, 1, 8'h43, 8'h00, 0);
    add(1, 1, 8'h50, 8'h99, 1, 1, 8'h43, 8'h84, 0,  0, 1, 8'h43, 8'h84, 0);
    add(1, 1, 8'h50, 8'h99, 1, 1, 8'h44, 8'h00, 0,  1, 0, 8'h50, 8'h99, 1);
    add(1, 0, 8'h50, 8'h99, 0, 1, 8'h44, 8'h00, 0,  1, 0, 8'h50, 8'h99, 0);
    add(1, 0, 8'h00, 8'h00, 0, 0, 8'h44, 8'h00, 0,  0, 1, 8'h44, 8'h00, 0);
    add(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0);
    // Asynchronous reset in the middle of a DMA tenure
    add(1, 0, 8'h00, 8'h00, 0, 1, 8'h60, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0);
    add(1, 0, 8'h00, 8'h00, 0, 1, 8'h60, 8'h00, 0,  0, 1, 8'h60, 8'h00, 0);
    add(1, 0, 8'h00, 8'h00, 0, 1, 8'h60, 8'h11, 1,  0, 1, 8'h60, 8'h11, 1);
    add(0, 1, 8'h00, 8'h00, 0, 1, 8'h61, 8'h12, 1,  0, 0, 8'h00, 8'h00, 0);
    add(1, 0, 8'h00, 8'h00, 0, 1, 8'h62, 8'h13, 1,  0, 0, 8'h00, 8'h00, 0);
    add(1, 0, 8'h00, 8'h00, 0, 0, 8'h62, 8'h00, 0,  0, 1, 8'h62, 8'h00, 0);
    add(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0);
    // dma_req dropped during a write cycle: pair completes, release after
    add(1, 0, 8'h00, 8'h00, 0, 1, 8'h70, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0);
    add(1, 0, 8'h00, 8'h00, 0, 1, 8'h70, 8'h00, 0,  0, 1, 8'h70, 8'h00, 0);
    add(1, 0, 8'h00, 8'h00, 0, 0, 8'h70, 8'hB1, 1,  0, 1, 8'h70, 8'hB1, 1);
    add(1, 0, 8'h00, 8'h00, 0, 0, 8'h71, 8'h00, 0,  0, 1, 8'h71, 8'h00, 0);
    add(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0,  0, 0, 8'h00, 8'h00, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].creq, vecs[i].caddr, vecs[i].cwd,
            vecs[i].cwe, vecs[i].dreq, vecs[i].daddr, vecs[i].dwd,
            vecs[i].dwe);
      #1;
      chk_outs($sformatf("vec%0d", i), vecs[i].e_cg, vecs[i].e_dg,
               vecs[i].creq & ~vecs[i].e_cg, vecs[i].e_addr, vecs[i].e_wd,
               vecs[i].e_we);
    end

    // Tie from idle, both requests held: CPU 4, DMA 8, repeating.
    do_reset();
    for (int c = 0; c <= 36; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 8'hC0, 8'hC1, 1'b1, 1'b1, 8'(8'hD0 + c), 8'hD1, 1'b1);
      #1;
      if (c == 0) begin
        ecg = 1'b0; edg = 1'b0;
      end else begin
        idx = (c - 1) % 12;
        ecg = (idx < 4);
        edg = !ecg;
      end
      chk_outs($sformatf("tie%0d", c), ecg, edg, !ecg,
               ecg ? 8'hC0 : (edg ? 8'(8'hD0 + c) : 8'h00),
               ecg ? 8'hC1 : (edg ? 8'hD1 : 8'h00), ecg | edg);
    end

    // CPU cycles without a waiting DMA do not count against the quantum.
    do_reset();
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 8'h55, 8'h66, 1'b0, (c >= 7), 8'hE0, 8'hE1, 1'b0);
      #1;
      ecg = (c >= 1) && (c <= 10);
      edg = (c == 11);
      chk($sformatf("quant%0d.cpu_grant", c), {7'd0, cpu_grant}, {7'd0, ecg});
      chk($sformatf("quant%0d.dma_grant", c), {7'd0, dma_grant}, {7'd0, edg});
    end

    do_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master RAM bus arbiter between the CPU data port and the DMA controller; owns the single RAM address/write port.
- Decides bus ownership each cycle and drives the DMA controller's bus_grant.
- Muxes address, write data and write enable from the current owner onto the RAM.
- RAM read data is wired directly to both masters and does not pass through this block.

Parameters:
- ADDR_W, 8, RAM address width
- DATA_W, 8, RAM data width
- CPU_QUANTUM, 4, max consecutive CPU-owned cycles while DMA is waiting (>=1)
- DMA_BURST, 4, max consecutive DMA read/write pairs while CPU is waiting (>=1)

Ports:
- clk  in  1  clock; all state on posedge
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- cpu_req  in  1  CPU wants the bus this cycle
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_we  in  1  CPU write enable
- cpu_grant  out  1  CPU owns the bus this cycle
- cpu_stall  out  1  cpu_req & ~cpu_grant (combinational)
- dma_req  in  1  DMA controller bus_req
- dma_addr  in  ADDR_W  DMA controller RAM address
- dma_wdata  in  DATA_W  DMA controller write data
- dma_we  in  1  DMA controller write enable
- dma_grant  out  1  DMA owns the bus; drives DMA controller bus_grant
- ram_addr  out  ADDR_W  muxed RAM address
- ram_wdata  out  DATA_W  muxed RAM write data
- ram_we  out  1  muxed RAM write enable

Behaviour:
- Registered state:
  - owner in {NONE, CPU, DMA}
  - phase bit: DMA tenure position; 0 = read cycle, 1 = write cycle
  - cpu_cnt: CPU-owned cycles this tenure
  - dma_cnt: completed DMA pairs this tenure
- Reset (rst=0, immediate, no clock needed): owner=NONE, phase=0, cpu_cnt=0, dma_cnt=0.
  - Resulting outputs: cpu_grant=0, dma_grant=0, ram_addr=0, ram_wdata=0, ram_we=0.
- Outputs are combinational from owner only:
  - cpu_grant = (owner==CPU); dma_grant = (owner==DMA).
  - ram_* = cpu_* when CPU owns, dma_* when DMA owns, all zero when NONE.
  - ram_we is additionally gated by the owner's grant: a non-owner write never reaches RAM.
- Latency: a request is granted at the earliest on the cycle after it is first sampled high. No combinational request-to-grant path.
- Transitions, evaluated at each posedge:
  - NONE:
    - cpu_req -> CPU (CPU wins a tie).
    - else dma_req -> DMA with phase=0.
    - else stay NONE.
  - CPU:
    - !cpu_req -> DMA if dma_req, else NONE.
    - cpu_req & dma_req & cpu_cnt==CPU_QUANTUM-1 -> DMA, phase=0.
    - else stay CPU, cpu_cnt++.
    - cpu_cnt increments only while dma_req=1 and saturates at CPU_QUANTUM-1.
  - DMA, phase=0 (read cycle):
    - dma_req=1 -> stay DMA, phase<=1. Unconditional: the DMA controller advances to its write cycle and must keep the bus.
    - dma_req=0 -> release: CPU if cpu_req, else NONE. This spends one idle granted cycle after the DMA controller's last write.
  - DMA, phase=1 (write cycle): phase<=0, then
    - cpu_req & dma_cnt==DMA_BURST-1 -> CPU, dma_cnt<=0.
    - else stay DMA, dma_cnt++ (saturating at DMA_BURST-1).
- Invariants:
  - Never switch owner from a phase=1 DMA cycle boundary into the middle of a read/write pair.
  - Never leave DMA at phase=1.
- Counters clear to 0 on every owner change.
- dma_req dropping during phase=1 is a protocol error; the arbiter still completes the pair and releases at the next phase=0 evaluation.
- cpu_grant and dma_grant are never both 1.

Test Plan:
- Reset:
  - Drive rst=0 mid-DMA tenure without a clock edge -> dma_grant, cpu_grant, ram_we drop to 0 immediately.
  - After rst=1, the first grant appears only after a posedge with a request.
- DMA alone:
  - Stimulus: dma_req held for 3 pairs, dma_we=1 on write cycles, then dropped.
  - dma_grant rises the cycle after dma_req and stays high 7 cycles (6 pair cycles + 1 release).
  - ram_addr follows dma_addr; ram_we=1 only on the 3 write cycles.
- Tie from idle, both requests held, CPU_QUANTUM=4, DMA_BURST=4 -> CPU 4 cycles, DMA 8 cycles, CPU 4 cycles, repeating; cpu_stall=1 exactly during DMA cycles.
- Pair integrity: cpu_req rises during a DMA read cycle with dma_cnt==DMA_BURST-1 -> DMA keeps the following write cycle, CPU is granted on the next cycle, no ram_we from the CPU during the DMA write.
- CPU alone, cpu_we=1, cpu_addr=8'h42, cpu_wdata=8'hA5:
  - Cycle 0: cpu_stall=1.
  - Cycle 1: cpu_grant=1, ram_addr=8'h42, ram_wdata=8'hA5, ram_we=1.
  - cpu_req low -> owner NONE, ram_addr=0.
- Non-owner write blocked: dma_we=1, dma_addr=8'h10 while CPU owns -> ram_we follows cpu_we only; address 8'h10 never appears on ram_addr.
